// File: rtl/mdu_if.sv
// Operand/request/result bundle between the controller datapath and the
// multiply/divide unit.
interface mdu_if;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic [2:0]  op;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output a, b, start, op, input busy, hi, lo);
    modport slave  (input a, b, start, op, output busy, hi, lo);
endinterface

// File: rtl/mdu.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO registers.
// One operand-latch edge, 32 shift-add/shift-subtract edges, one sign-fix edge.
module mdu (
    input  logic  i_clk,
    input  logic  i_rst_n,
    mdu_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    state_t      r_state;
    logic [4:0]  r_count;
    logic [63:0] r_acc;
    logic [31:0] r_opnd;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_signed;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic        w_b_zero;
    logic [32:0] w_mul_sum;
    logic        w_div_ge;
    logic [31:0] w_div_sub;
    logic [63:0] w_prod_neg;

    // Even opcodes among 000..011 are the signed variants.
    assign w_signed  = ~bus.op[0];
    assign w_abs_a   = (w_signed && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
    assign w_abs_b   = (w_signed && bus.b[31]) ? (32'd0 - bus.b) : bus.b;
    assign w_b_zero  = (bus.b == 32'd0);

    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
    assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);

    // Divide: the partial remainder shifted left is r_acc[63:31] (33 bits);
    // when it is >= divisor the difference always fits back in 32 bits.
    assign w_div_ge  = (r_acc[63:31] >= {1'b0, r_opnd});
    assign w_div_sub = r_acc[62:31] - r_opnd;

    assign w_prod_neg = 64'd0 - r_acc;

    assign bus.busy = (r_state != S_IDLE);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_count  <= 5'd0;
            r_acc    <= 64'd0;
            r_opnd   <= 32'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.op[2] == 1'b0) begin
                            r_acc    <= {32'd0, w_abs_a};
                            r_opnd   <= w_abs_b;
                            r_is_div <= bus.op[1];
                            // Divide-by-zero keeps the all-ones quotient unsigned.
                            r_neg_q  <= w_signed && (bus.a[31] ^ bus.b[31]) &&
                                        !(bus.op[1] && w_b_zero);
                            r_neg_r  <= w_signed && bus.a[31];
                            r_count  <= 5'd0;
                            r_state  <= S_RUN;
                        end else if (bus.op == OP_MTHI) begin
                            r_hi <= bus.a;
                        end else if (bus.op == OP_MTLO) begin
                            r_lo <= bus.a;
                        end
                    end
                end
                S_RUN: begin
                    if (r_is_div) begin
                        if (w_div_ge)
                            r_acc <= {w_div_sub, r_acc[30:0], 1'b1};
                        else
                            r_acc <= {r_acc[62:0], 1'b0};
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[31:1]};
                    end
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31)
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
                        r_lo <= r_neg_q ? (32'd0 - r_acc[31:0])  : r_acc[31:0];
                    end else begin
                        {r_hi, r_lo} <= r_neg_q ? w_prod_neg : r_acc;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected HI/LO, a negedge monitor
// pops on each Busy fall and also checks occupancy length and HI/LO hold.
module tb_mdu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;
    exp_t exp_q[$];

    mdu_if bus();
    mdu dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.busy) begin
            failures++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", nm, bus.busy, n);
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        e.hi = ehi; e.lo = elo; e.name = nm;
        exp_q.push_back(e);
        issue(op, a, b);
        wait_idle(nm);
    endtask

    task automatic move_to(input string nm, input logic [2:0] op, input logic [31:0] a);
        issue(op, a, 32'd0);
        chk({nm, "_busy"}, {31'd0, bus.busy}, 32'd0);
        if (op == 3'b100) chk({nm, "_hi"}, bus.hi, a);
        else              chk({nm, "_lo"}, bus.lo, a);
    endtask

    // Monitor: completion = Busy falling while out of reset.
    initial begin
        logic        prev_busy = 1'b0;
        int          busy_len = 0;
        logic [31:0] snap_hi = '0;
        logic [31:0] snap_lo = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 1'b0;
                busy_len = 0;
            end else begin
                if (bus.busy) begin
                    if (!prev_busy) begin
                        snap_hi = bus.hi; snap_lo = bus.lo; busy_len = 0;
                    end
                    busy_len++;
                    if (bus.hi !== snap_hi || bus.lo !== snap_lo) begin
                        checks++; failures++;
                        $display("FAIL hold_during_busy: hi=%h lo=%h required hi=%h lo=%h",
                                 bus.hi, bus.lo, snap_hi, snap_lo);
                    end
                end else if (prev_busy) begin
                    chk("busy_cycles", busy_len, 32'd33);
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_completion: hi=%h lo=%h required none", bus.hi, bus.lo);
                    end else begin
                        e = exp_q.pop_front();
                        chk({e.name, "_hi"}, bus.hi, e.hi);
                        chk({e.name, "_lo"}, bus.lo, e.lo);
                    end
                end
                if (bus.hi === 32'h0000DEAD) begin
                    checks++; failures++;
                    $display("FAIL hi_dead: hi=%h required not 0000dead", bus.hi);
                end
                prev_busy = bus.busy;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);
        rst_n = 1'b1;

        // MTHI then MTLO on consecutive edges with Start held.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'h12345678;
        @(posedge clk); #1;
        chk("mthi_hi", bus.hi, 32'h12345678);
        chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
        bus.op = 3'b101; bus.a = 32'h9ABCDEF0;
        @(posedge clk); #1;
        chk("mtlo_lo", bus.lo, 32'h9ABCDEF0);
        chk("mtlo_hi", bus.hi, 32'h12345678);
        chk("mtlo_busy", {31'd0, bus.busy}, 32'd0);
        bus.start = 1'b0;

        // Op 110 is a no-op.
        issue(3'b110, 32'h11111111, 32'd0);
        chk("nop_busy", {31'd0, bus.busy}, 32'd0);
        chk("nop_hi", bus.hi, 32'h12345678);

        run_op("mult_neg3x7",   3'b000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("multu_max",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("div_neg7by2",   3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_100by7",   3'b011, 32'd100,      32'd7,        32'd2,        32'd14);
        run_op("div_min_neg1",  3'b010, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000);
        run_op("divu_by_zero",  3'b011, 32'hCAFEF00D, 32'd0,        32'hCAFEF00D, 32'hFFFFFFFF);
        run_op("div_by_zero",   3'b010, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF);
        run_op("mult_min_min",  3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run_op("div_7by_neg2",  3'b010, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);

        // Start pulses while busy must be ignored.
        begin
            exp_t e;
            e.hi = 32'd0; e.lo = 32'd15; e.name = "mult_3x5_busy_ignore";
            exp_q.push_back(e);
        end
        issue(3'b000, 32'd3, 32'd5);
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'h0000DEAD;
        @(negedge clk);
        bus.op = 3'b010; bus.a = 32'd100; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle("mult_3x5_busy_ignore");

        // Reset at count=10 of a DIVU.
        move_to("mthi_pre_reset", 3'b100, 32'h000055AA);
        issue(3'b011, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_busy", {31'd0, bus.busy}, 32'd0);
        chk("midreset_hi", bus.hi, 32'd0);
        chk("midreset_lo", bus.lo, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op("multu_6x7", 3'b001, 32'd6, 32'd7, 32'd0, 32'd42);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
